// File: rtl/thread_pkg.sv
// Shared definitions for the per-thread PC scheduler.
//   thread_state_e : per-thread lifecycle state (FREE / RUN / HOLD)
//   HANDLER        : PC loaded when the optional bound check
//                    (THREAD_PC_BOUND_CHK_EN) rejects a target
//   NUM_THREAD_DEF, RESET_PC_DEF : default top-level configuration
package thread_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } thread_state_e;

    localparam int          NUM_THREAD_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

    // Out-of-range jump/spawn targets are redirected here (word address).
    localparam logic [31:0] HANDLER        = 32'h0000_0F00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   eligible  [NUM_THREAD] : request mask
//   ptr       [TID_W]      : index where the search starts
//   grant_vld              : at least one request present
//   grant_idx [TID_W]      : first requesting index at or after ptr (wrapping)
// NUM_THREAD must be a power of two so that index arithmetic wraps naturally.
module rr_arbiter #(
    parameter int NUM_THREAD = 4,
    parameter int TID_W      = $clog2(NUM_THREAD)
) (
    input  logic [NUM_THREAD-1:0] eligible,
    input  logic [TID_W-1:0]      ptr,
    output logic                  grant_vld,
    output logic [TID_W-1:0]      grant_idx
);

    always_comb begin
        logic             found;
        logic [TID_W-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant_idx = '0;
        grant_vld = |eligible;
        for (int i = 0; i < NUM_THREAD; i++) begin
            // Wrapping add: power-of-two thread count makes this mod NUM_THREAD.
            idx = ptr + TID_W'(i);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/thread_pc_sched.sv
// Per-thread PC scheduler in front of the fetch stage.
// Keeps one PC per hardware thread, picks a RUN thread round-robin and
// offers its PC to fetch with a valid/ready handshake. Applies execute-stage
// redirects, thread spawn/kill, and emits a registered flush pulse.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   spawn_en/spawn_tid/spawn_pc   : start a FREE thread at spawn_pc
//   kill_en/kill_tid              : retire a thread
//   jmp_en/jmp_tid/jmp_pc         : taken redirect from execute
//   fetch_rdy                     : fetch accepts this cycle
//   fetch_vld/fetch_pc/fetch_tid  : offered fetch request
//   flush_vld/flush_tid           : one-cycle flush of younger in-flight instrs
//   thread_act                    : per-thread "not FREE"
//   trap_vld                      : bound-check trap pulse
// Optional feature macro: THREAD_PC_BOUND_CHK_EN (targets >= IMEM_DEPTH are
// replaced by HANDLER and raise trap_vld). Without it trap_vld is tied 0.
module thread_pc_sched
    import thread_pkg::*;
#(
    parameter int          NUM_THREAD = NUM_THREAD_DEF,
    parameter int          TID_W      = $clog2(NUM_THREAD),
    parameter int          FLUSH_CYC  = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IMEM_DEPTH = 32'h0000_4000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spawn_en,
    input  logic [TID_W-1:0]      spawn_tid,
    input  logic [31:0]           spawn_pc,
    input  logic                  kill_en,
    input  logic [TID_W-1:0]      kill_tid,
    input  logic                  jmp_en,
    input  logic [TID_W-1:0]      jmp_tid,
    input  logic [31:0]           jmp_pc,
    input  logic                  fetch_rdy,
    output logic                  fetch_vld,
    output logic [31:0]           fetch_pc,
    output logic [TID_W-1:0]      fetch_tid,
    output logic                  flush_vld,
    output logic [TID_W-1:0]      flush_tid,
    output logic [NUM_THREAD-1:0] thread_act,
    output logic                  trap_vld
);

`ifdef THREAD_PC_BOUND_CHK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic [NUM_THREAD-1:0] run_vec;
    logic [NUM_THREAD-1:0] act_vec;
    logic [31:0]           pc_arr [NUM_THREAD];
    logic [TID_W-1:0]      rr_ptr_reg;
    logic                  grant_vld;
    logic [TID_W-1:0]      grant_idx;
    logic                  fire;

    rr_arbiter #(.NUM_THREAD(NUM_THREAD), .TID_W(TID_W)) u_arb (
        .eligible  (run_vec),
        .ptr       (rr_ptr_reg),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    // Outputs derive from registered state only; rst_n gating keeps
    // fetch_vld low while reset is held even though thread 0 resets to RUN.
    assign fetch_vld  = grant_vld & rst_n;
    assign fetch_tid  = grant_idx;
    assign fetch_pc   = pc_arr[grant_idx];
    assign fire       = fetch_vld & fetch_rdy;
    assign thread_act = act_vec;

    // Accepted events. Kill beats jump on the same tid; events on FREE
    // threads (other than spawn) are dropped.
    logic kill_acc, jmp_acc, jmp_oob, spawn_oob;
    logic [31:0] jmp_tgt, spawn_tgt;
    assign kill_acc  = kill_en && act_vec[kill_tid];
    assign jmp_acc   = jmp_en && act_vec[jmp_tid] && !(kill_acc && kill_tid == jmp_tid);
    assign jmp_oob   = BOUND_EN && (jmp_pc >= IMEM_DEPTH);
    assign spawn_oob = BOUND_EN && (spawn_pc >= IMEM_DEPTH);
    assign jmp_tgt   = jmp_oob ? HANDLER : jmp_pc;
    assign spawn_tgt = spawn_oob ? HANDLER : spawn_pc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_THREAD; gi++) begin : gen_thr
            thread_state_e state_reg;
            logic [31:0]   pc_reg;
            logic [2:0]    hold_cnt_reg;
            logic          kill_hit, jmp_hit, spawn_hit, fetch_hit;

            assign kill_hit  = kill_en  && (kill_tid  == TID_W'(gi));
            assign jmp_hit   = jmp_en   && (jmp_tid   == TID_W'(gi));
            assign spawn_hit = spawn_en && (spawn_tid == TID_W'(gi));
            assign fetch_hit = fire     && (grant_idx == TID_W'(gi));

            assign run_vec[gi] = (state_reg == RUN);
            assign act_vec[gi] = (state_reg != FREE);
            assign pc_arr[gi]  = pc_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    if (gi == 0) begin
                        state_reg <= RUN;
                        pc_reg    <= RESET_PC;
                    end else begin
                        state_reg <= FREE;
                        pc_reg    <= '0;
                    end
                    hold_cnt_reg <= '0;
                end else begin
                    case (state_reg)
                        FREE: begin
                            if (spawn_hit && !kill_hit) begin
                                state_reg <= RUN;
                                pc_reg    <= spawn_tgt;
                            end
                        end
                        default: begin
                            if (kill_hit) begin
                                state_reg <= FREE;
                            end else if (jmp_hit) begin
                                // A same-cycle fetch of this thread is wrong-path;
                                // the target wins over pc+1.
                                state_reg    <= HOLD;
                                pc_reg       <= jmp_tgt;
                                hold_cnt_reg <= 3'(FLUSH_CYC);
                            end else if (state_reg == HOLD) begin
                                hold_cnt_reg <= hold_cnt_reg - 3'd1;
                                if (hold_cnt_reg == 3'd1)
                                    state_reg <= RUN;
                            end else if (fetch_hit) begin
                                pc_reg <= pc_reg + 32'd1;
                            end
                        end
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_reg <= '0;
        else if (fire)
            rr_ptr_reg <= grant_idx + TID_W'(1);
    end

    // Flush sequencing: a kill flush goes out first, then any pending jump
    // flush, then a fresh jump flush. A jump that cannot go out this cycle
    // parks in the one-entry pending register. If the entry is already full
    // while a kill and a jump arrive together, the newest jump replaces it.
    logic             flush_vld_reg;
    logic [TID_W-1:0] flush_tid_reg;
    logic             pend_vld_reg;
    logic [TID_W-1:0] pend_tid_reg;
    logic             pend_load;

    assign pend_load = jmp_acc && (kill_acc || pend_vld_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_vld_reg <= 1'b0;
            flush_tid_reg <= '0;
            pend_vld_reg  <= 1'b0;
            pend_tid_reg  <= '0;
        end else begin
            flush_vld_reg <= kill_acc | pend_vld_reg | jmp_acc;
            if (kill_acc)
                flush_tid_reg <= kill_tid;
            else if (pend_vld_reg)
                flush_tid_reg <= pend_tid_reg;
            else if (jmp_acc)
                flush_tid_reg <= jmp_tid;

            if (pend_load) begin
                pend_vld_reg <= 1'b1;
                pend_tid_reg <= jmp_tid;
            end else if (!kill_acc) begin
                pend_vld_reg <= 1'b0;
            end
        end
    end

    assign flush_vld = flush_vld_reg;
    assign flush_tid = flush_tid_reg;

`ifdef THREAD_PC_BOUND_CHK_EN
    // The trap bit travels with its jump flush (including the pending slot),
    // so it lines up with that flush pulse. A rejected spawn has no flush and
    // just pulses trap on the following cycle.
    logic trap_reg;
    logic pend_trap_reg;
    logic spawn_trap;

    assign spawn_trap = spawn_en && spawn_oob && !act_vec[spawn_tid]
                        && !(kill_en && kill_tid == spawn_tid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_reg      <= 1'b0;
            pend_trap_reg <= 1'b0;
        end else begin
            trap_reg <= spawn_trap
                        || (!kill_acc && (pend_vld_reg ? pend_trap_reg : (jmp_acc && jmp_oob)));
            if (pend_load)
                pend_trap_reg <= jmp_oob;
        end
    end

    assign trap_vld = trap_reg;
`else
    assign trap_vld = 1'b0;
`endif

endmodule

// File: tb/tb_thread_pc_sched.sv
// Self-checking bench for thread_pc_sched: a reference model predicts the
// offered fetch request, thread activity and flush/trap pulses; a separate
// negedge monitor pops the predictions and compares them with the DUT.
module tb_thread_pc_sched;
    import thread_pkg::*;

    localparam int          NT    = 4;
    localparam int          TW    = 2;
    localparam int          FC    = 2;
    localparam logic [31:0] DEPTH = 32'h0000_4000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            spawn_en = 1'b0, kill_en = 1'b0, jmp_en = 1'b0, fetch_rdy = 1'b0;
    logic [TW-1:0]   spawn_tid = '0, kill_tid = '0, jmp_tid = '0;
    logic [31:0]     spawn_pc = '0, jmp_pc = '0;
    logic            fetch_vld, flush_vld, trap_vld;
    logic [31:0]     fetch_pc;
    logic [TW-1:0]   fetch_tid, flush_tid;
    logic [NT-1:0]   thread_act;

    thread_pc_sched #(
        .NUM_THREAD(NT), .TID_W(TW), .FLUSH_CYC(FC),
        .RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .spawn_en(spawn_en), .spawn_tid(spawn_tid), .spawn_pc(spawn_pc),
        .kill_en(kill_en), .kill_tid(kill_tid),
        .jmp_en(jmp_en), .jmp_tid(jmp_tid), .jmp_pc(jmp_pc),
        .fetch_rdy(fetch_rdy),
        .fetch_vld(fetch_vld), .fetch_pc(fetch_pc), .fetch_tid(fetch_tid),
        .flush_vld(flush_vld), .flush_tid(flush_tid),
        .thread_act(thread_act), .trap_vld(trap_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic        vld;
        logic [TW-1:0] tid;
        logic [31:0] pc;
        logic [NT-1:0] act;
    } fetch_exp_t;

    typedef struct {
        int          due;
        logic [TW-1:0] tid;
        logic        trap;
    } flush_exp_t;

    fetch_exp_t exp_fetch[$];
    flush_exp_t exp_flush[$];
    flush_exp_t m_pend[$];

    // Reference model: liveness flag, PC and the first step a thread may be
    // fetched again after a redirect.
    bit          m_alive [NT];
    logic [31:0] m_pc    [NT];
    int          m_resume[NT];
    int          m_ptr;
    int          m_cyc;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef THREAD_PC_BOUND_CHK_EN
        return (p >= DEPTH) ? HANDLER : p;
`else
        return p;
`endif
    endfunction

    function automatic logic oob(input logic [31:0] p);
`ifdef THREAD_PC_BOUND_CHK_EN
        return p >= DEPTH;
`else
        return 1'b0 & p[0];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_alive[i]  = (i == 0);
            m_pc[i]     = 32'h0;
            m_resume[i] = 0;
        end
        m_ptr = 0;
        m_cyc = 0;
        m_pend.delete();
        exp_fetch.delete();
        exp_flush.delete();
    endtask

    function automatic int model_sel();
        int s;
        s = -1;
        for (int k = 0; k < NT; k++) begin
            int t;
            t = (m_ptr + k) % NT;
            if (s < 0 && m_alive[t] && m_cyc >= m_resume[t]) s = t;
        end
        return s;
    endfunction

    // Predict this cycle's outputs from the current inputs, then advance.
    task automatic model_step();
        fetch_exp_t fe;
        flush_exp_t cand[$];
        flush_exp_t f;
        int  sel;
        bit  fire, k_ok, j_ok, s_ok;
        logic [NT-1:0] act;

        sel = model_sel();
        for (int i = 0; i < NT; i++) act[i] = m_alive[i];
        fe.step = m_cyc;
        fe.vld  = (sel >= 0);
        fe.tid  = (sel >= 0) ? TW'(sel) : '0;
        fe.pc   = (sel >= 0) ? m_pc[sel] : '0;
        fe.act  = act;
        exp_fetch.push_back(fe);
        fire = (sel >= 0) && fetch_rdy;

        k_ok = kill_en && m_alive[kill_tid];
        j_ok = jmp_en && m_alive[jmp_tid] && !(k_ok && kill_tid == jmp_tid);
        s_ok = spawn_en && !m_alive[spawn_tid] && !(kill_en && kill_tid == spawn_tid);

        // Flush order: kill first, then older pending jump, then this jump.
        if (k_ok) begin f.due = 0; f.tid = kill_tid; f.trap = 1'b0; cand.push_back(f); end
        foreach (m_pend[i]) cand.push_back(m_pend[i]);
        if (j_ok) begin f.due = 0; f.tid = jmp_tid; f.trap = oob(jmp_pc); cand.push_back(f); end
        m_pend.delete();
        if (cand.size() > 0) begin
            f = cand.pop_front();
            f.due = m_cyc + 1;
            exp_flush.push_back(f);
            foreach (cand[i]) m_pend.push_back(cand[i]);
        end

        if (fire) begin
            m_pc[sel] = m_pc[sel] + 32'd1;
            m_ptr = (sel + 1) % NT;
        end
        if (j_ok) begin
            m_pc[jmp_tid]     = tgt(jmp_pc);
            m_resume[jmp_tid] = m_cyc + FC + 1;
        end
        if (k_ok) m_alive[kill_tid] = 1'b0;
        if (s_ok) begin
            m_alive[spawn_tid]  = 1'b1;
            m_pc[spawn_tid]     = tgt(spawn_pc);
            m_resume[spawn_tid] = 0;
        end
        m_cyc++;
    endtask

    task automatic step(input logic s_en, input logic [TW-1:0] s_tid, input logic [31:0] s_pc,
                        input logic k_en, input logic [TW-1:0] k_tid,
                        input logic j_en, input logic [TW-1:0] j_tid, input logic [31:0] j_pc,
                        input logic rdy);
        spawn_en = s_en; spawn_tid = s_tid; spawn_pc = s_pc;
        kill_en  = k_en; kill_tid  = k_tid;
        jmp_en   = j_en; jmp_tid   = j_tid; jmp_pc = j_pc;
        fetch_rdy = rdy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(0, '0, '0, 0, '0, 0, '0, '0, rdy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fetch_vld"}, fetch_vld, 0);
        chk({tag, "_flush_vld"}, flush_vld, 0);
        chk({tag, "_flush_tid"}, flush_tid, 0);
        chk({tag, "_trap_vld"}, trap_vld, 0);
        chk({tag, "_thread_act"}, thread_act, 4'b0001);
    endtask

    // Monitor: one prediction per cycle; flush predictions are tagged with
    // the step in which the pulse must appear.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_fetch.size() == 0) begin
                chk("fetch_queue_empty", 1, 0);
            end else begin
                fetch_exp_t e;
                e = exp_fetch.pop_front();
                chk("fetch_vld", fetch_vld, e.vld);
                if (e.vld) begin
                    chk("fetch_tid", fetch_tid, e.tid);
                    chk("fetch_pc", fetch_pc, e.pc);
                end
                chk("thread_act", thread_act, e.act);
                if (exp_flush.size() > 0 && exp_flush[0].due == e.step) begin
                    flush_exp_t f;
                    f = exp_flush.pop_front();
                    chk("flush_vld", flush_vld, 1);
                    if (flush_vld) chk("flush_tid", flush_tid, f.tid);
                    chk("trap_vld", trap_vld, f.trap);
                end else begin
                    chk("flush_idle", flush_vld, 0);
                    chk("trap_idle", trap_vld, 0);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset state while rst_n is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Thread 0 alone: PCs 0,1,2,3.
        idle(4, 1);
        // Spawn t1 @0x100 and t2 @0x200, watch interleaving.
        step(1, 2'd1, 32'h100, 0, '0, 0, '0, '0, 1);
        step(1, 2'd2, 32'h200, 0, '0, 0, '0, '0, 1);
        idle(6, 1);
        // Redirect t1 to 0x40.
        step(0, '0, '0, 0, '0, 1, 2'd1, 32'h40, 1);
        idle(5, 1);
        // Jump t0 in the same cycle t0 is being fetched.
        guard = 0;
        while (model_sel() != 0 && guard < 8) begin idle(1, 1); guard++; end
        chk("t0_selected", model_sel(), 0);
        step(0, '0, '0, 0, '0, 1, 2'd0, 32'h80, 1);
        idle(4, 1);
        // Kill and jump t2 together, then stall fetch.
        step(0, '0, '0, 1, 2'd2, 1, 2'd2, 32'h300, 1);
        idle(5, 0);
        idle(2, 1);
        // Out-of-range target, and a target near the 32-bit wrap.
        step(0, '0, '0, 0, '0, 1, 2'd0, 32'h5000, 1);
        idle(4, 1);
        step(0, '0, '0, 0, '0, 1, 2'd1, 32'hFFFF_FFFE, 1);
        idle(8, 1);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic s_en, k_en, j_en, rdy;
            logic [31:0] jp;
            s_en = ($urandom_range(0, 99) < 20);
            k_en = ($urandom_range(0, 99) < 8);
            j_en = ($urandom_range(0, 99) < 25);
            rdy  = ($urandom_range(0, 99) < 75);
            if (m_pend.size() > 0 && k_en && j_en) j_en = 1'b0;
            jp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                             : 32'($urandom_range(0, 32'h3FFF));
            step(s_en, TW'($urandom_range(0, NT - 1)), 32'($urandom_range(0, 32'h3FFF)),
                 k_en, TW'($urandom_range(0, NT - 1)),
                 j_en, TW'($urandom_range(0, NT - 1)), jp, rdy);
        end
        idle(6, 1);
        chk("flush_queue_drained", exp_flush.size(), 0);

        // Reset asserted mid-operation.
        step(1, 2'd3, 32'h123, 0, '0, 1, 2'd0, 32'h77, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        idle(6, 1);
        @(negedge clk);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
